// File: rtl/tms1x_pkg.sv
// Shared definitions for the TMS1x00 core: execution phases, fixed opcodes and
// the bit-reversal helpers used to decode immediate constants.
package tms1x_pkg;

    typedef enum logic {
        PH_FETCH,
        PH_EXEC
    } phase_t;

    localparam logic [7:0] OP_MNEA   = 8'h00;
    localparam logic [7:0] OP_ALEM   = 8'h01;
    localparam logic [7:0] OP_YNEA   = 8'h02;
    localparam logic [7:0] OP_XMA    = 8'h03;
    localparam logic [7:0] OP_DYN    = 8'h04;
    localparam logic [7:0] OP_IYC    = 8'h05;
    localparam logic [7:0] OP_AMAAC  = 8'h06;
    localparam logic [7:0] OP_DMAN   = 8'h07;
    localparam logic [7:0] OP_TKA    = 8'h08;
    localparam logic [7:0] OP_COMX   = 8'h09;
    localparam logic [7:0] OP_TDO    = 8'h0A;
    localparam logic [7:0] OP_COMC   = 8'h0B;
    localparam logic [7:0] OP_RSTR   = 8'h0C;
    localparam logic [7:0] OP_SETR   = 8'h0D;
    localparam logic [7:0] OP_KNEZ   = 8'h0E;
    localparam logic [7:0] OP_RETN   = 8'h0F;
    localparam logic [7:0] OP_TAY    = 8'h20;
    localparam logic [7:0] OP_TMA    = 8'h21;
    localparam logic [7:0] OP_TMY    = 8'h22;
    localparam logic [7:0] OP_TYA    = 8'h23;
    localparam logic [7:0] OP_TAMDYN = 8'h24;
    localparam logic [7:0] OP_TAMIYC = 8'h25;
    localparam logic [7:0] OP_TAMZA  = 8'h26;
    localparam logic [7:0] OP_TAM    = 8'h27;
    localparam logic [7:0] OP_SAMAN  = 8'h3C;
    localparam logic [7:0] OP_CPAIY  = 8'h3D;
    localparam logic [7:0] OP_IMAC   = 8'h3E;
    localparam logic [7:0] OP_MNEZ   = 8'h3F;
    localparam logic [7:0] OP_CLA    = 8'h7F;

    function automatic logic [1:0] bitrev2(input logic [1:0] v);
        return {v[0], v[1]};
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/tms1x_alu.sv
// 4-bit adder with carry-in; subtraction is done by the caller feeding ~b with
// cin=1, so carry doubles as the no-borrow flag.
module tms1x_alu (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry,
    output logic       eq
);

    always_comb begin
        {carry, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        eq           = (a == b);
    end

endmodule

// File: rtl/tms1x00_core.sv
// TMS1000/TMS1100-compatible 4-bit core: two-clock fetch/execute over an
// external synchronous ROM, internal 128x4 RAM, O and R output latches.
module tms1x00_core (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        mode_tms1100,
    input  logic        cpu_en,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic [3:0]  k_in,
    output logic [7:0]  o_out,
    output logic [10:0] r_out
);
    import tms1x_pkg::*;

    phase_t      phase;
    logic [5:0]  pc, sr, n_pc, n_sr;
    logic [3:0]  pa, pb, n_pa, n_pb;
    logic        ca, cb, cs, cl, n_ca, n_cb, n_cs, n_cl;
    logic        s, sl, n_s, n_sl;
    logic [3:0]  a, y, n_a, n_y;
    logic [2:0]  x, n_x;
    logic [7:0]  n_o;
    logic [10:0] n_r, r_mask;

    logic [3:0]  ram [0:127];
    logic [6:0]  ram_addr;
    logic [3:0]  m, ram_wd;
    logic        ram_we;

    logic [7:0]  op;
    logic [3:0]  c;
    logic [1:0]  bsel;
    logic [3:0]  alu_a, alu_b, alu_sum;
    logic        alu_cin, alu_carry, alu_eq;

    assign op       = rom_data;
    assign c        = bitrev4(op[3:0]);
    assign bsel     = bitrev2(op[1:0]);
    assign rom_addr = {ca & mode_tms1100, pa, pc};
    assign ram_addr = mode_tms1100 ? {x, y} : {1'b0, x[1:0], y};
    assign m        = ram[ram_addr];
    // Y >= 11 shifts the bit out of the 11-bit mask, so RSTR/SETR become no-ops.
    assign r_mask   = 11'd1 << y;

    tms1x_alu u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .cin   (alu_cin),
        .sum   (alu_sum),
        .carry (alu_carry),
        .eq    (alu_eq)
    );

    always_comb begin
        alu_a   = a;
        alu_b   = m;
        alu_cin = 1'b0;
        casez (op)
            OP_MNEA:                begin alu_a = m; alu_b = a; end
            OP_ALEM, OP_SAMAN:      begin alu_a = m; alu_b = ~a; alu_cin = 1'b1; end
            OP_YNEA:                begin alu_a = y; alu_b = a; end
            OP_DYN, OP_TAMDYN:      begin alu_a = y; alu_b = 4'hF; end
            OP_IYC, OP_TAMIYC:      begin alu_a = y; alu_b = 4'h0; alu_cin = 1'b1; end
            OP_DMAN:                begin alu_a = m; alu_b = 4'hF; end
            OP_CPAIY:               begin alu_a = 4'h0; alu_b = ~a; alu_cin = 1'b1; end
            OP_IMAC:                begin alu_a = m; alu_b = 4'h0; alu_cin = 1'b1; end
            8'b0101_????:           begin alu_a = y; alu_b = c; end
            8'b0111_????:           begin alu_a = a; alu_b = c; alu_cin = 1'b1; end
            default:                ;
        endcase
    end

    always_comb begin
        n_pc = pc;  n_sr = sr;  n_pa = pa;  n_pb = pb;
        n_ca = ca;  n_cb = cb;  n_cs = cs;  n_cl = cl;
        n_s  = 1'b1; n_sl = sl;
        n_a  = a;   n_x  = x;   n_y  = y;
        n_o  = o_out; n_r = r_out;
        ram_we = 1'b0;
        ram_wd = a;
        casez (op)
            OP_MNEA, OP_YNEA:   begin n_s = ~alu_eq; n_sl = ~alu_eq; end
            OP_ALEM:            n_s = alu_carry;
            OP_XMA:             begin n_a = m; ram_we = 1'b1; end
            OP_DYN, OP_IYC:     begin n_y = alu_sum; n_s = alu_carry; end
            OP_AMAAC, OP_DMAN, OP_SAMAN, OP_IMAC:
                                begin n_a = alu_sum; n_s = alu_carry; end
            OP_TKA:             n_a = k_in;
            OP_COMX:            n_x = x ^ (mode_tms1100 ? 3'b100 : 3'b011);
            OP_TDO:             n_o = {sl, 3'b000, a};
            OP_COMC:            n_cb = ~cb;
            OP_RSTR:            n_r = r_out & ~r_mask;
            OP_SETR:            n_r = r_out | r_mask;
            OP_KNEZ:            n_s = (k_in != 4'h0);
            OP_RETN:            begin n_pc = sr; n_pa = pb; n_ca = cs; n_cl = 1'b0; end
            8'b0001_????:       n_pb = c;
            OP_TAY:             n_y = a;
            OP_TMA:             n_a = m;
            OP_TMY:             n_y = m;
            OP_TYA:             n_a = y;
            OP_TAMDYN, OP_TAMIYC:
                                begin ram_we = 1'b1; n_y = alu_sum; n_s = alu_carry; end
            OP_TAMZA:           begin ram_we = 1'b1; n_a = '0; end
            OP_TAM:             ram_we = 1'b1;
            8'b0010_1???:       n_x = bitrev3(op[2:0]);
            8'b0011_00??:       begin ram_we = 1'b1; ram_wd = m | (4'b0001 << bsel); end
            8'b0011_01??:       begin ram_we = 1'b1; ram_wd = m & ~(4'b0001 << bsel); end
            8'b0011_10??:       n_s = m[bsel];
            OP_CPAIY:           begin n_a = alu_sum; n_y = y + 4'd1; n_s = (alu_sum == 4'h0); end
            OP_MNEZ:            n_s = (m != 4'h0);
            8'b0100_????:       n_y = c;
            8'b0101_????:       begin n_s = ~alu_eq; n_sl = ~alu_eq; end
            8'b0110_????:       begin ram_we = 1'b1; ram_wd = c; n_y = y + 4'd1; end
            8'b0111_????: begin
                if (op == OP_CLA) begin
                    n_a = '0;
                end else begin
                    n_a = alu_sum;
                    n_s = alu_carry;
                end
            end
            8'b1???_????: begin
                // BR and CALL share the taken path; CALL inside a subroutine degrades to BR.
                if (s) begin
                    n_pc = op[5:0];
                    n_ca = cb;
                    if (!cl) begin
                        n_pa = pb;
                        if (op[6]) begin
                            n_sr = pc;
                            n_pb = pa;
                            n_cs = ca;
                            n_cl = 1'b1;
                        end
                    end
                end
            end
            default:            ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            phase <= PH_FETCH;
            pc <= '0;  sr <= '0;
            pa <= '1;  pb <= '1;
            ca <= 1'b0; cb <= 1'b0; cs <= 1'b0; cl <= 1'b0;
            s  <= 1'b1; sl <= 1'b0;
            a  <= '0;  x  <= '0;  y  <= '0;
            o_out <= '0;
            r_out <= '0;
        end else if (cpu_en) begin
            if (phase == PH_FETCH) begin
                pc    <= pc + 6'd1;
                phase <= PH_EXEC;
            end else begin
                pc <= n_pc;  sr <= n_sr;  pa <= n_pa;  pb <= n_pb;
                ca <= n_ca;  cb <= n_cb;  cs <= n_cs;  cl <= n_cl;
                s  <= n_s;   sl <= n_sl;
                a  <= n_a;   x  <= n_x;   y  <= n_y;
                o_out <= n_o;
                r_out <= n_r;
                phase <= PH_FETCH;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && cpu_en && phase == PH_EXEC && ram_we)
            ram[ram_addr] <= ram_wd;
    end

endmodule

// File: tb/tb_tms1x00_core.sv
// Directed-program bench for tms1x00_core: a synchronous ROM model feeds
// short hand-assembled programs and outputs are checked against hand results.
module tb_tms1x00_core;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        mode_tms1100 = 1'b1;
    logic        cpu_en = 1'b1;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  k_in = 4'h0;
    logic [7:0]  o_out;
    logic [10:0] r_out;

    logic [7:0]  rom [2048];
    int          checks = 0;
    int          errors = 0;

    tms1x00_core dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .mode_tms1100 (mode_tms1100),
        .cpu_en       (cpu_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .k_in         (k_in),
        .o_out        (o_out),
        .r_out        (r_out)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) rom_data <= rom[rom_addr];

    task automatic clear_rom;
        for (int i = 0; i < 2048; i++) rom[i] = 8'h20;
    endtask

    task automatic do_reset;
        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (2 * n) @(negedge wb_clk_i);
    endtask

    task automatic test_reset;
        clear_rom();
        mode_tms1100 = 1'b1;
        do_reset();
        checks++; if (rom_addr !== 11'h3C0) begin errors++; $display("FAIL reset rom_addr: got %h want 3c0", rom_addr); end
        checks++; if (o_out !== 8'h00) begin errors++; $display("FAIL reset o_out: got %h want 00", o_out); end
        checks++; if (r_out !== 11'h000) begin errors++; $display("FAIL reset r_out: got %h want 000", r_out); end
        run(1);
        checks++; if (rom_addr !== 11'h3C1) begin errors++; $display("FAIL second_fetch rom_addr: got %h want 3c1", rom_addr); end
    endtask

    task automatic test_ram_path;
        logic [7:0] prog [8] = '{8'h2C, 8'h09, 8'h40, 8'h6A, 8'h2D, 8'h40, 8'h21, 8'h0A};
        clear_rom();
        foreach (prog[i]) rom[11'h3C0 + 11'(i)] = prog[i];
        mode_tms1100 = 1'b1;
        do_reset();
        run(8);
        checks++; if (o_out !== 8'h05) begin errors++; $display("FAIL ram_path o_out: got %h want 05", o_out); end
    endtask

    task automatic test_chapter;
        clear_rom();
        rom[11'h3C0] = 8'h0B; rom[11'h3C1] = 8'h80;
        rom[11'h7C0] = 8'h0B; rom[11'h7C1] = 8'h80;
        mode_tms1100 = 1'b1;
        do_reset();
        run(2);
        checks++; if (rom_addr !== 11'h7C0) begin errors++; $display("FAIL chapter_set rom_addr: got %h want 7c0", rom_addr); end
        run(2);
        checks++; if (rom_addr !== 11'h3C0) begin errors++; $display("FAIL chapter_clear rom_addr: got %h want 3c0", rom_addr); end
        mode_tms1100 = 1'b0;
        do_reset();
        run(2);
        checks++; if (rom_addr !== 11'h3C0) begin errors++; $display("FAIL chapter_tms1000 rom_addr: got %h want 3c0", rom_addr); end
        mode_tms1100 = 1'b1;
    endtask

    task automatic test_accum;
        logic [7:0] prog [13] = '{8'h70, 8'h90, 8'h0A, 8'h7F, 8'h78, 8'h78, 8'h78,
                                  8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'hA0};
        clear_rom();
        foreach (prog[i]) rom[11'h3C0 + 11'(i)] = prog[i];
        rom[11'h3E0] = 8'h0A;
        mode_tms1100 = 1'b1;
        do_reset();
        run(2);
        checks++; if (rom_addr !== 11'h3C2) begin errors++; $display("FAIL br_not_taken rom_addr: got %h want 3c2", rom_addr); end
        run(1);
        checks++; if (o_out !== 8'h01) begin errors++; $display("FAIL iac o_out: got %h want 01", o_out); end
        run(10);
        checks++; if (rom_addr !== 11'h3E0) begin errors++; $display("FAIL a2aac_carry_br rom_addr: got %h want 3e0", rom_addr); end
        run(1);
        checks++; if (o_out !== 8'h00) begin errors++; $display("FAIL a2aac_wrap o_out: got %h want 00", o_out); end
    endtask

    task automatic test_sl_compare;
        logic [7:0] prog [6] = '{8'h4C, 8'h5A, 8'h0A, 8'h5C, 8'h80, 8'h0A};
        clear_rom();
        foreach (prog[i]) rom[11'h3C0 + 11'(i)] = prog[i];
        mode_tms1100 = 1'b1;
        do_reset();
        run(3);
        checks++; if (o_out !== 8'h80) begin errors++; $display("FAIL ynec_sl_set o_out: got %h want 80", o_out); end
        run(2);
        checks++; if (rom_addr !== 11'h3C5) begin errors++; $display("FAIL ynec_equal_br rom_addr: got %h want 3c5", rom_addr); end
        run(1);
        checks++; if (o_out !== 8'h00) begin errors++; $display("FAIL ynec_sl_clear o_out: got %h want 00", o_out); end
    endtask

    task automatic test_alu;
        logic [7:0] prog [9] = '{8'h40, 8'h6C, 8'h40, 8'h72, 8'h3C, 8'h80, 8'h0A, 8'h07, 8'h90};
        clear_rom();
        foreach (prog[i]) rom[11'h3C0 + 11'(i)] = prog[i];
        rom[11'h3D0] = 8'h0A;
        mode_tms1100 = 1'b1;
        do_reset();
        run(6);
        checks++; if (rom_addr !== 11'h3C6) begin errors++; $display("FAIL saman_borrow_br rom_addr: got %h want 3c6", rom_addr); end
        run(1);
        checks++; if (o_out !== 8'h0E) begin errors++; $display("FAIL saman o_out: got %h want 0e", o_out); end
        run(2);
        checks++; if (rom_addr !== 11'h3D0) begin errors++; $display("FAIL dman_br rom_addr: got %h want 3d0", rom_addr); end
        run(1);
        checks++; if (o_out !== 8'h02) begin errors++; $display("FAIL dman o_out: got %h want 02", o_out); end
    endtask

    task automatic test_k_input;
        logic [7:0] prog [6] = '{8'h08, 8'h0A, 8'h0E, 8'h80, 8'h0E, 8'hA0};
        clear_rom();
        foreach (prog[i]) rom[11'h3C0 + 11'(i)] = prog[i];
        mode_tms1100 = 1'b1;
        k_in = 4'h6;
        do_reset();
        run(2);
        checks++; if (o_out !== 8'h06) begin errors++; $display("FAIL tka o_out: got %h want 06", o_out); end
        k_in = 4'h0;
        run(2);
        checks++; if (rom_addr !== 11'h3C4) begin errors++; $display("FAIL knez_zero rom_addr: got %h want 3c4", rom_addr); end
        k_in = 4'h2;
        run(2);
        checks++; if (rom_addr !== 11'h3E0) begin errors++; $display("FAIL knez_set rom_addr: got %h want 3e0", rom_addr); end
        k_in = 4'h0;
    endtask

    task automatic test_ram_isolation;
        logic [7:0] p1 [14] = '{8'h28, 8'h40, 8'h6C, 8'h29, 8'h40, 8'h69, 8'h28,
                                8'h40, 8'h21, 8'h0A, 8'h29, 8'h40, 8'h21, 8'h0A};
        logic [7:0] p2 [11] = '{8'h29, 8'h40, 8'h69, 8'h28, 8'h40, 8'h21, 8'h0A,
                                8'h29, 8'h40, 8'h21, 8'h0A};
        clear_rom();
        foreach (p1[i]) rom[11'h3C0 + 11'(i)] = p1[i];
        mode_tms1100 = 1'b1;
        do_reset();
        run(10);
        checks++; if (o_out !== 8'h03) begin errors++; $display("FAIL ram1100_x0 o_out: got %h want 03", o_out); end
        run(4);
        checks++; if (o_out !== 8'h09) begin errors++; $display("FAIL ram1100_x4 o_out: got %h want 09", o_out); end
        clear_rom();
        foreach (p2[i]) rom[11'h3C0 + 11'(i)] = p2[i];
        mode_tms1100 = 1'b0;
        do_reset();
        run(7);
        checks++; if (o_out !== 8'h09) begin errors++; $display("FAIL ram1000_alias_x0 o_out: got %h want 09", o_out); end
        run(4);
        checks++; if (o_out !== 8'h09) begin errors++; $display("FAIL ram1000_x4 o_out: got %h want 09", o_out); end
        mode_tms1100 = 1'b1;
    endtask

    task automatic test_call_retn;
        clear_rom();
        rom[11'h3C0] = 8'h14; rom[11'h3C1] = 8'hD0;
        rom[11'h090] = 8'hE0;
        rom[11'h0A0] = 8'h45; rom[11'h0A1] = 8'h0D; rom[11'h0A2] = 8'h0F;
        rom[11'h3C2] = 8'h14; rom[11'h3C3] = 8'hB0;
        rom[11'h0B0] = 8'h0C; rom[11'h0B1] = 8'h4D; rom[11'h0B2] = 8'h0D;
        mode_tms1100 = 1'b1;
        do_reset();
        run(2);
        checks++; if (rom_addr !== 11'h090) begin errors++; $display("FAIL call rom_addr: got %h want 090", rom_addr); end
        run(1);
        checks++; if (rom_addr !== 11'h0A0) begin errors++; $display("FAIL inner_call_as_br rom_addr: got %h want 0a0", rom_addr); end
        run(3);
        checks++; if (rom_addr !== 11'h3C2) begin errors++; $display("FAIL retn rom_addr: got %h want 3c2", rom_addr); end
        checks++; if (r_out !== 11'h400) begin errors++; $display("FAIL setr_r10 r_out: got %h want 400", r_out); end
        run(2);
        checks++; if (rom_addr !== 11'h0B0) begin errors++; $display("FAIL cl_cleared_br rom_addr: got %h want 0b0", rom_addr); end
        run(1);
        checks++; if (r_out !== 11'h000) begin errors++; $display("FAIL rstr_r10 r_out: got %h want 000", r_out); end
        run(2);
        checks++; if (r_out !== 11'h000) begin errors++; $display("FAIL setr_y11_ignored r_out: got %h want 000", r_out); end
    endtask

    task automatic test_pc_wrap;
        clear_rom();
        rom[11'h3C0] = 8'hBF;
        rom[11'h3FF] = 8'h0A;
        mode_tms1100 = 1'b1;
        do_reset();
        run(1);
        checks++; if (rom_addr !== 11'h3FF) begin errors++; $display("FAIL br_3f rom_addr: got %h want 3ff", rom_addr); end
        run(1);
        checks++; if (rom_addr !== 11'h3C0) begin errors++; $display("FAIL pc_wrap rom_addr: got %h want 3c0", rom_addr); end
    endtask

    task automatic test_hold;
        clear_rom();
        rom[11'h3C0] = 8'h70; rom[11'h3C1] = 8'h0A;
        mode_tms1100 = 1'b1;
        do_reset();
        cpu_en = 1'b0;
        run(2);
        checks++; if (rom_addr !== 11'h3C0) begin errors++; $display("FAIL hold rom_addr: got %h want 3c0", rom_addr); end
        cpu_en = 1'b1;
        run(2);
        checks++; if (o_out !== 8'h01) begin errors++; $display("FAIL hold_resume o_out: got %h want 01", o_out); end
        checks++; if (rom_addr !== 11'h3C2) begin errors++; $display("FAIL hold_resume rom_addr: got %h want 3c2", rom_addr); end
    endtask

    task automatic test_reset_exec;
        clear_rom();
        rom[11'h3C0] = 8'h70; rom[11'h3C1] = 8'h0A; rom[11'h3C2] = 8'h0D;
        mode_tms1100 = 1'b1;
        do_reset();
        run(2);
        checks++; if (o_out !== 8'h01) begin errors++; $display("FAIL pre_abort o_out: got %h want 01", o_out); end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        checks++; if (r_out !== 11'h000) begin errors++; $display("FAIL abort r_out: got %h want 000", r_out); end
        checks++; if (rom_addr !== 11'h3C0) begin errors++; $display("FAIL abort rom_addr: got %h want 3c0", rom_addr); end
        run(2);
        checks++; if (o_out !== 8'h01) begin errors++; $display("FAIL abort_a_cleared o_out: got %h want 01", o_out); end
    endtask

    initial begin
        test_reset();
        test_ram_path();
        test_chapter();
        test_accum();
        test_sl_compare();
        test_alu();
        test_k_input();
        test_ram_isolation();
        test_call_retn();
        test_pc_wrap();
        test_hold();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
